// File: rtl/sbox_share_ctrl.sv
// Time-shares LANES combinational S-box lookups between the round datapath (S, 16 bytes)
// and the key schedule (W, 4 bytes), one job at a time, LANES bytes per beat.
module sbox_share_ctrl #(
  parameter int LANES    = 4,
  parameter int ARB_MODE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               st_valid,
  output logic               st_ready,
  input  logic [127:0]       st_in,
  output logic               st_out_valid,
  output logic [127:0]       st_out,
  input  logic               wd_valid,
  output logic               wd_ready,
  input  logic [31:0]        wd_in,
  output logic               wd_out_valid,
  output logic [31:0]        wd_out,
  output logic [8*LANES-1:0] sbox_addr,
  input  logic [8*LANES-1:0] sbox_data,
  output logic               busy
);

  generate
    if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_lanes_check
      $error("sbox_share_ctrl: LANES must be 1, 2 or 4");
    end
  endgenerate

  localparam logic [3:0] LAST_S = 4'(16 / LANES - 1);
  localparam logic [3:0] LAST_W = 4'(4 / LANES - 1);
  // A W word sits in buffer bytes 12..15 (the low 32 bits)
  localparam int W_BASE = 12;

  typedef enum logic [1:0] {IDLE, RUN_S, RUN_W} state_t;

  state_t             state_q, state_d;
  logic [127:0]       buf_q, buf_d;
  logic [127:0]       res_q, res_d;
  logic [127:0]       st_out_q, st_out_d;
  logic [31:0]        wd_out_q, wd_out_d;
  logic               st_out_valid_q, st_out_valid_d;
  logic               wd_out_valid_q, wd_out_valid_d;
  logic [8*LANES-1:0] addr_q, addr_d;
  logic [3:0]         beat_q, beat_d;
  logic [3:0]         last_beat;
  logic               last_w_q, last_w_d;
  logic               busy_q, busy_d;
  logic               idle;
  int                 first_byte;
  logic [7:0]         lane_data [LANES];

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_data[gi] = sbox_data[8*gi +: 8];
    end
  endgenerate

  function automatic logic [8*LANES-1:0] lane_bytes(input logic [127:0] src, input int first);
    logic [8*LANES-1:0] r;
    r = '0;
    for (int k = 0; k < LANES; k++) begin
      r[8*k +: 8] = src[8*(15-(first+k)) +: 8];
    end
    return r;
  endfunction

  assign idle = (state_q == IDLE);

  always_comb begin
    st_ready = 1'b0;
    wd_ready = 1'b0;
    if (idle) begin
      if (ARB_MODE == 1) begin
        wd_ready = 1'b1;
        st_ready = ~wd_valid;
      end else begin
        wd_ready = ~st_valid | ~last_w_q;
        st_ready = ~wd_valid | last_w_q;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    buf_d          = buf_q;
    res_d          = res_q;
    beat_d         = beat_q;
    st_out_d       = st_out_q;
    wd_out_d       = wd_out_q;
    st_out_valid_d = 1'b0;
    wd_out_valid_d = 1'b0;
    addr_d         = '0;
    last_w_d       = last_w_q;
    first_byte     = ((state_q == RUN_W) ? W_BASE : 0) + int'(beat_q) * LANES;
    last_beat      = (state_q == RUN_W) ? LAST_W : LAST_S;
    case (state_q)
      IDLE: begin
        if (wd_valid && wd_ready) begin
          state_d  = RUN_W;
          buf_d    = {96'b0, wd_in};
          beat_d   = '0;
          last_w_d = 1'b1;
          addr_d   = lane_bytes({96'b0, wd_in}, W_BASE);
        end else if (st_valid && st_ready) begin
          state_d  = RUN_S;
          buf_d    = st_in;
          beat_d   = '0;
          last_w_d = 1'b0;
          addr_d   = lane_bytes(st_in, 0);
        end
      end
      RUN_S, RUN_W: begin
        for (int k = 0; k < LANES; k++) begin
          res_d[8*(15-(first_byte+k)) +: 8] = lane_data[k];
        end
        if (beat_q == last_beat) begin
          state_d = IDLE;
          beat_d  = '0;
          if (state_q == RUN_S) begin
            st_out_d       = res_d;
            st_out_valid_d = 1'b1;
          end else begin
            wd_out_d       = res_d[31:0];
            wd_out_valid_d = 1'b1;
          end
        end else begin
          beat_d = beat_q + 4'd1;
          // Registered address for the following beat
          addr_d = lane_bytes(buf_q, first_byte + LANES);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      buf_q          <= '0;
      res_q          <= '0;
      beat_q         <= '0;
      st_out_q       <= '0;
      wd_out_q       <= '0;
      st_out_valid_q <= 1'b0;
      wd_out_valid_q <= 1'b0;
      addr_q         <= '0;
      last_w_q       <= 1'b1;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      buf_q          <= buf_d;
      res_q          <= res_d;
      beat_q         <= beat_d;
      st_out_q       <= st_out_d;
      wd_out_q       <= wd_out_d;
      st_out_valid_q <= st_out_valid_d;
      wd_out_valid_q <= wd_out_valid_d;
      addr_q         <= addr_d;
      last_w_q       <= last_w_d;
      busy_q         <= busy_d;
    end
  end

  assign st_out       = st_out_q;
  assign wd_out       = wd_out_q;
  assign st_out_valid = st_out_valid_q;
  assign wd_out_valid = wd_out_valid_q;
  assign sbox_addr    = addr_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_sbox_share_ctrl.sv
// Bench for sbox_share_ctrl: three instances (LANES=4 fixed priority, LANES=4 round-robin,
// LANES=1), an arithmetic AES S-box model per lane, and a result/latency scoreboard.
module tb_sbox_share_ctrl;

  localparam logic [127:0] VEC_S = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] EXP_S = 128'h638293c31bfc33f5c4eeacea4bc12816;
  localparam logic [31:0]  VEC_W = 32'hcf4f3c09;
  localparam logic [31:0]  EXP_W = 32'h8a84eb01;

  typedef struct {
    logic [127:0] d;
    int           c;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;

  logic         a_st_valid, a_st_ready, a_st_out_valid, a_wd_valid, a_wd_ready, a_wd_out_valid, a_busy;
  logic [127:0] a_st_in, a_st_out;
  logic [31:0]  a_wd_in, a_wd_out, a_sbox_addr, a_sbox_data;
  logic         r_st_valid, r_st_ready, r_st_out_valid, r_wd_valid, r_wd_ready, r_wd_out_valid, r_busy;
  logic [127:0] r_st_in, r_st_out;
  logic [31:0]  r_wd_in, r_wd_out, r_sbox_addr, r_sbox_data;
  logic         l_st_valid, l_st_ready, l_st_out_valid, l_wd_valid, l_wd_ready, l_wd_out_valid, l_busy;
  logic [127:0] l_st_in, l_st_out;
  logic [31:0]  l_wd_in, l_wd_out;
  logic [7:0]   l_sbox_addr, l_sbox_data;

  exp_t q_as[$], q_aw[$], q_rs[$], q_rw[$], q_ls[$], q_lw[$];
  exp_t e;

  sbox_share_ctrl #(.LANES(4), .ARB_MODE(1)) u_a (
    .clk(clk), .rst_n(rst_n),
    .st_valid(a_st_valid), .st_ready(a_st_ready), .st_in(a_st_in),
    .st_out_valid(a_st_out_valid), .st_out(a_st_out),
    .wd_valid(a_wd_valid), .wd_ready(a_wd_ready), .wd_in(a_wd_in),
    .wd_out_valid(a_wd_out_valid), .wd_out(a_wd_out),
    .sbox_addr(a_sbox_addr), .sbox_data(a_sbox_data), .busy(a_busy)
  );

  sbox_share_ctrl #(.LANES(4), .ARB_MODE(0)) u_r (
    .clk(clk), .rst_n(rst_n),
    .st_valid(r_st_valid), .st_ready(r_st_ready), .st_in(r_st_in),
    .st_out_valid(r_st_out_valid), .st_out(r_st_out),
    .wd_valid(r_wd_valid), .wd_ready(r_wd_ready), .wd_in(r_wd_in),
    .wd_out_valid(r_wd_out_valid), .wd_out(r_wd_out),
    .sbox_addr(r_sbox_addr), .sbox_data(r_sbox_data), .busy(r_busy)
  );

  sbox_share_ctrl #(.LANES(1), .ARB_MODE(1)) u_l (
    .clk(clk), .rst_n(rst_n),
    .st_valid(l_st_valid), .st_ready(l_st_ready), .st_in(l_st_in),
    .st_out_valid(l_st_out_valid), .st_out(l_st_out),
    .wd_valid(l_wd_valid), .wd_ready(l_wd_ready), .wd_in(l_wd_in),
    .wd_out_valid(l_wd_out_valid), .wd_out(l_wd_out),
    .sbox_addr(l_sbox_addr), .sbox_data(l_sbox_data), .busy(l_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    logic       hi;
    p = '0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      hi = x[7];
      x  = {x[6:0], 1'b0};
      if (hi) x = x ^ 8'h1b;
      y  = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // Multiplicative inverse as v^254, then the AES affine transform
  function automatic logic [7:0] sbox(input logic [7:0] v);
    logic [7:0] t, inv;
    t = v; inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      t   = gmul(t, t);
      inv = gmul(inv, t);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub128(input logic [127:0] x);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox(x[8*i +: 8]);
    return r;
  endfunction

  function automatic logic [127:0] sub32(input logic [31:0] x);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sbox(x[8*i +: 8]);
    return r;
  endfunction

  always_comb begin
    a_sbox_data = '0;
    r_sbox_data = '0;
    for (int k = 0; k < 4; k++) begin
      a_sbox_data[8*k +: 8] = sbox(a_sbox_addr[8*k +: 8]);
      r_sbox_data[8*k +: 8] = sbox(r_sbox_addr[8*k +: 8]);
    end
    l_sbox_data = sbox(l_sbox_addr);
  end

  // Scoreboard: push on accept with the required completion cycle, pop on each result pulse
  always @(negedge clk) begin
    #3;
    if (!rst_n) begin
      q_as.delete(); q_aw.delete(); q_rs.delete(); q_rw.delete(); q_ls.delete(); q_lw.delete();
    end else begin
      if (a_st_out_valid) begin
        checks++;
        if (q_as.size() == 0) begin failures++; $display("FAIL a_st_unexpected_pulse got=%h", a_st_out); end
        else begin
          e = q_as.pop_front();
          if (a_st_out !== e.d || cyc != e.c) begin failures++; $display("FAIL a_st_result got=%h@%0d exp=%h@%0d", a_st_out, cyc, e.d, e.c); end
          else $display("a S done st_out=%h cycle=%0d", a_st_out, cyc);
        end
      end
      if (a_wd_out_valid) begin
        checks++;
        if (q_aw.size() == 0) begin failures++; $display("FAIL a_wd_unexpected_pulse got=%h", a_wd_out); end
        else begin
          e = q_aw.pop_front();
          if ({96'b0, a_wd_out} !== e.d || cyc != e.c) begin failures++; $display("FAIL a_wd_result got=%h@%0d exp=%h@%0d", a_wd_out, cyc, e.d[31:0], e.c); end
          else $display("a W done wd_out=%h cycle=%0d", a_wd_out, cyc);
        end
      end
      if (r_st_out_valid) begin
        checks++;
        if (q_rs.size() == 0) begin failures++; $display("FAIL r_st_unexpected_pulse got=%h", r_st_out); end
        else begin
          e = q_rs.pop_front();
          if (r_st_out !== e.d || cyc != e.c) begin failures++; $display("FAIL r_st_result got=%h@%0d exp=%h@%0d", r_st_out, cyc, e.d, e.c); end
          else $display("r S done st_out=%h cycle=%0d", r_st_out, cyc);
        end
      end
      if (r_wd_out_valid) begin
        checks++;
        if (q_rw.size() == 0) begin failures++; $display("FAIL r_wd_unexpected_pulse got=%h", r_wd_out); end
        else begin
          e = q_rw.pop_front();
          if ({96'b0, r_wd_out} !== e.d || cyc != e.c) begin failures++; $display("FAIL r_wd_result got=%h@%0d exp=%h@%0d", r_wd_out, cyc, e.d[31:0], e.c); end
          else $display("r W done wd_out=%h cycle=%0d", r_wd_out, cyc);
        end
      end
      if (l_st_out_valid) begin
        checks++;
        if (q_ls.size() == 0) begin failures++; $display("FAIL l_st_unexpected_pulse got=%h", l_st_out); end
        else begin
          e = q_ls.pop_front();
          if (l_st_out !== e.d || cyc != e.c) begin failures++; $display("FAIL l_st_result got=%h@%0d exp=%h@%0d", l_st_out, cyc, e.d, e.c); end
          else $display("l S done st_out=%h cycle=%0d", l_st_out, cyc);
        end
      end
      if (l_wd_out_valid) begin
        checks++;
        if (q_lw.size() == 0) begin failures++; $display("FAIL l_wd_unexpected_pulse got=%h", l_wd_out); end
        else begin
          e = q_lw.pop_front();
          if ({96'b0, l_wd_out} !== e.d || cyc != e.c) begin failures++; $display("FAIL l_wd_result got=%h@%0d exp=%h@%0d", l_wd_out, cyc, e.d[31:0], e.c); end
          else $display("l W done wd_out=%h cycle=%0d", l_wd_out, cyc);
        end
      end
      if (a_st_valid && a_st_ready) q_as.push_back('{sub128(a_st_in), cyc + 1 + 4});
      if (a_wd_valid && a_wd_ready) q_aw.push_back('{sub32(a_wd_in), cyc + 1 + 1});
      if (r_st_valid && r_st_ready) q_rs.push_back('{sub128(r_st_in), cyc + 1 + 4});
      if (r_wd_valid && r_wd_ready) q_rw.push_back('{sub32(r_wd_in), cyc + 1 + 1});
      if (l_st_valid && l_st_ready) q_ls.push_back('{sub128(l_st_in), cyc + 1 + 16});
      if (l_wd_valid && l_wd_ready) q_lw.push_back('{sub32(l_wd_in), cyc + 1 + 4});
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #4;
    checks++; if (a_busy !== 1'b0 || r_busy !== 1'b0 || l_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b%b%b exp=000", a_busy, r_busy, l_busy); end
    checks++; if (a_st_out_valid !== 1'b0 || a_wd_out_valid !== 1'b0) begin failures++; $display("FAIL reset_valids got=%b%b exp=00", a_st_out_valid, a_wd_out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    #4;
    checks++; if (a_st_out !== '0 || a_wd_out !== '0) begin failures++; $display("FAIL reset_outputs got=%h/%h exp=0", a_st_out, a_wd_out); end
    checks++; if (a_sbox_addr !== '0 || l_sbox_addr !== '0) begin failures++; $display("FAIL reset_addr got=%h/%h exp=0", a_sbox_addr, l_sbox_addr); end
    checks++; if (a_st_ready !== 1'b1 || a_wd_ready !== 1'b1 || r_st_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b%b%b exp=111", a_st_ready, a_wd_ready, r_st_ready); end
    $display("reset done");
  endtask

  task automatic test_s_only();
    int n;
    @(negedge clk);
    a_st_in = VEC_S; a_st_valid = 1'b1;
    #4;
    checks++; if (a_st_ready !== 1'b1) begin failures++; $display("FAIL s_only_ready got=%b exp=1", a_st_ready); end
    @(negedge clk);
    a_st_valid = 1'b0;
    #4;
    checks++; if (a_busy !== 1'b1 || a_sbox_addr !== 32'h33221100) begin failures++; $display("FAIL s_only_beat0 busy=%b addr=%h exp busy=1 addr=33221100", a_busy, a_sbox_addr); end
    checks++; if (a_st_ready !== 1'b0) begin failures++; $display("FAIL s_only_ready_busy got=%b exp=0", a_st_ready); end
    n = 0;
    do begin @(negedge clk); #4; n++; end while (a_st_out_valid !== 1'b1 && n < 40);
    checks++; if (a_st_out !== EXP_S || n != 4) begin failures++; $display("FAIL s_only_result got=%h after %0d exp=%h after 4", a_st_out, n, EXP_S); end
    checks++; if (a_st_ready !== 1'b1 || a_busy !== 1'b0) begin failures++; $display("FAIL s_only_idle_on_pulse ready=%b busy=%b exp 1/0", a_st_ready, a_busy); end
    @(negedge clk);
    #4;
    checks++; if (a_st_out_valid !== 1'b0 || a_st_out !== EXP_S) begin failures++; $display("FAIL s_only_hold valid=%b st_out=%h exp 0/%h", a_st_out_valid, a_st_out, EXP_S); end
  endtask

  task automatic test_w_only();
    int n;
    @(negedge clk);
    a_wd_in = VEC_W; a_wd_valid = 1'b1;
    @(negedge clk);
    a_wd_valid = 1'b0;
    #4;
    checks++; if (a_busy !== 1'b1 || a_sbox_addr !== 32'h093c4fcf) begin failures++; $display("FAIL w_only_beat0 busy=%b addr=%h exp busy=1 addr=093c4fcf", a_busy, a_sbox_addr); end
    n = 0;
    do begin @(negedge clk); #4; n++; end while (a_wd_out_valid !== 1'b1 && n < 40);
    checks++; if (a_wd_out !== EXP_W || n != 1) begin failures++; $display("FAIL w_only_result got=%h after %0d exp=%h after 1", a_wd_out, n, EXP_W); end
    checks++; if (a_st_out !== EXP_S) begin failures++; $display("FAIL w_only_st_hold got=%h exp=%h", a_st_out, EXP_S); end
  endtask

  task automatic test_reset_abort();
    logic seen;
    @(negedge clk);
    a_st_in = VEC_S; a_st_valid = 1'b1;
    @(negedge clk);
    a_st_valid = 1'b0;
    @(negedge clk);
    #4;
    checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL abort_running got=%b exp=1", a_busy); end
    @(negedge clk);
    rst_n = 1'b0;
    #4;
    checks++; if (a_st_out !== '0 || a_busy !== 1'b0 || a_sbox_addr !== '0) begin failures++; $display("FAIL abort_cleared st_out=%h busy=%b addr=%h exp 0", a_st_out, a_busy, a_sbox_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #4;
      if (a_st_out_valid === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    #4;
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_pulse got=%b exp=0", seen); end
    checks++; if (a_st_ready !== 1'b1 || a_busy !== 1'b0 || a_st_out !== '0) begin failures++; $display("FAIL abort_idle ready=%b busy=%b st_out=%h exp 1/0/0", a_st_ready, a_busy, a_st_out); end
    $display("abort done");
  endtask

  task automatic test_contention_fixed();
    int n;
    @(negedge clk);
    a_st_in = VEC_S; a_wd_in = 32'h0; a_st_valid = 1'b1; a_wd_valid = 1'b1;
    #4;
    checks++; if (a_wd_ready !== 1'b1 || a_st_ready !== 1'b0) begin failures++; $display("FAIL fixed_grant wd_ready=%b st_ready=%b exp 1/0", a_wd_ready, a_st_ready); end
    @(negedge clk);
    a_wd_valid = 1'b0;
    #4;
    checks++; if (a_st_ready !== 1'b0) begin failures++; $display("FAIL fixed_s_waits got=%b exp=0", a_st_ready); end
    n = 0;
    do begin @(negedge clk); #4; n++; end while (a_wd_out_valid !== 1'b1 && n < 40);
    checks++; if (a_wd_out !== 32'h63636363 || a_st_out_valid !== 1'b0 || n != 1) begin failures++; $display("FAIL fixed_w_first wd_out=%h st_v=%b after %0d exp 63636363/0 after 1", a_wd_out, a_st_out_valid, n); end
    checks++; if (a_st_ready !== 1'b1) begin failures++; $display("FAIL fixed_s_next got=%b exp=1", a_st_ready); end
    @(negedge clk);
    a_st_valid = 1'b0;
    n = 0;
    do begin #4; n++; if (a_st_out_valid !== 1'b1) @(negedge clk); end while (a_st_out_valid !== 1'b1 && n < 40);
    checks++; if (a_st_out !== EXP_S || n != 4) begin failures++; $display("FAIL fixed_s_second got=%h after %0d exp=%h after 4", a_st_out, n, EXP_S); end
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    a_st_in = {16{8'hff}}; a_st_valid = 1'b1;
    @(negedge clk);
    a_st_in = '0;
    n = 0;
    do begin @(negedge clk); #4; n++; end while (a_st_out_valid !== 1'b1 && n < 40);
    checks++; if (a_st_out !== {16{8'h16}} || n != 4) begin failures++; $display("FAIL b2b_first got=%h after %0d exp=%h after 4", a_st_out, n, {16{8'h16}}); end
    checks++; if (a_st_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_on_pulse got=%b exp=1", a_st_ready); end
    @(negedge clk);
    a_st_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); #4; n++; end while (a_st_out_valid !== 1'b1 && n < 40);
    checks++; if (a_st_out !== {16{8'h63}} || n != 4) begin failures++; $display("FAIL b2b_second got=%h after %0d exp=%h after 4", a_st_out, n, {16{8'h63}}); end
  endtask

  task automatic test_round_robin();
    int  n;
    logic exp_w;
    @(negedge clk);
    r_st_in = VEC_S; r_wd_in = VEC_W; r_st_valid = 1'b1;
    @(negedge clk);
    r_st_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); #4; n++; end while (r_st_out_valid !== 1'b1 && n < 40);
    checks++; if (r_st_out !== EXP_S) begin failures++; $display("FAIL rr_s_only got=%h exp=%h", r_st_out, EXP_S); end
    @(negedge clk);
    r_st_valid = 1'b1; r_wd_valid = 1'b1;
    #4;
    for (int g = 0; g < 4; g++) begin
      exp_w = (g % 2 == 0);
      n = 0;
      while (r_busy !== 1'b0 && n < 40) begin @(negedge clk); #4; n++; end
      checks++;
      if (r_wd_ready !== exp_w || r_st_ready !== !exp_w) begin failures++; $display("FAIL rr_grant%0d wd_ready=%b st_ready=%b exp %b/%b", g, r_wd_ready, r_st_ready, exp_w, !exp_w); end
      else $display("r grant %0d to %s", g, exp_w ? "W" : "S");
      @(negedge clk);
      #4;
    end
    r_st_valid = 1'b0; r_wd_valid = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_lanes1();
    int n;
    @(negedge clk);
    l_st_in = VEC_S; l_st_valid = 1'b1;
    @(negedge clk);
    l_st_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); #4; n++; end while (l_st_out_valid !== 1'b1 && n < 60);
    checks++; if (l_st_out !== EXP_S || n != 16) begin failures++; $display("FAIL l1_s_result got=%h after %0d exp=%h after 16", l_st_out, n, EXP_S); end
    @(negedge clk);
    l_wd_in = VEC_W; l_wd_valid = 1'b1;
    @(negedge clk);
    l_wd_valid = 1'b0;
    #4;
    checks++; if (l_sbox_addr !== 8'hcf) begin failures++; $display("FAIL l1_w_beat0 addr=%h exp=cf", l_sbox_addr); end
    n = 0;
    do begin @(negedge clk); #4; n++; end while (l_wd_out_valid !== 1'b1 && n < 60);
    checks++; if (l_wd_out !== EXP_W || n != 4) begin failures++; $display("FAIL l1_w_result got=%h after %0d exp=%h after 4", l_wd_out, n, EXP_W); end
  endtask

  task automatic test_drain();
    int left;
    repeat (20) @(negedge clk);
    #4;
    left = q_as.size() + q_aw.size() + q_rs.size() + q_rw.size() + q_ls.size() + q_lw.size();
    checks++; if (left != 0) begin failures++; $display("FAIL drain_outstanding got=%0d exp=0", left); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0;
    a_st_valid = 1'b0; a_wd_valid = 1'b0; a_st_in = '0; a_wd_in = '0;
    r_st_valid = 1'b0; r_wd_valid = 1'b0; r_st_in = '0; r_wd_in = '0;
    l_st_valid = 1'b0; l_wd_valid = 1'b0; l_st_in = '0; l_wd_in = '0;
    test_reset();
    test_s_only();
    test_w_only();
    test_reset_abort();
    test_contention_fixed();
    test_back_to_back();
    test_round_robin();
    test_lanes1();
    test_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
